mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the IF-stage instruction fetch and the
//  MEM-stage load/store port of the five-stage MIPS pipeline. Grants one request at a time,

---
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the IF-stage fetch port and the
// MEM-stage load/store port: data first, bounded fetch starvation, response timeout.
module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  // load/store port
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  // pipeline stalls
  output logic          stall_if,
  output logic          stall_mem,
  // memory side
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TIMER_LIM  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_e;

  state_e          state_q,   state_d;
  owner_e          owner_q,   owner_d;
  logic [SW-1:0]   starve_q,  starve_d;
  logic [TW-1:0]   timer_q,   timer_d;
  logic            m_en_q,    m_en_d;
  logic            m_we_q,    m_we_d;
  logic [AW-1:0]   m_addr_q,  m_addr_d;
  logic [DW-1:0]   m_wdata_q, m_wdata_d;
  logic            i_ack_q,   i_ack_d;
  logic            d_ack_q,   d_ack_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            err_q,     err_d;

  logic            starved;
  logic            grant_d;
  logic            grant_i;
  logic            rsp_done;
  logic [DW-1:0]   rsp_data;

  // Data wins a tie unless the fetch side has already lost STARVE_MAX ties in a row.
  assign starved  = (starve_q == STARVE_LIM);
  assign grant_d  = d_req & ~(i_req & starved);
  assign grant_i  = i_req & ~grant_d;

  // A timed-out access completes like a normal one but returns zero data.
  assign rsp_done = m_ack | (timer_q == TIMER_LIM);
  assign rsp_data = m_ack ? m_rdata : '0;

  always_comb begin
    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    timer_d   = timer_q;
    m_en_d    = 1'b0;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_d) begin
          state_d   = ST_BUSY;
          owner_d   = OWN_D;
          m_en_d    = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          timer_d   = TW'(1);
          if (i_req) begin
            starve_d = starved ? starve_q : starve_q + SW'(1);
          end else begin
            starve_d = '0;
          end
        end else if (grant_i) begin
          state_d   = ST_BUSY;
          owner_d   = OWN_I;
          m_en_d    = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_wdata_d = '0;
          timer_d   = TW'(1);
          starve_d  = '0;
        end
      end

      ST_BUSY: begin
        if (rsp_done) begin
          state_d = ST_DONE;
          if (!m_ack) begin
            err_d = 1'b1;
          end
          if (owner_q == OWN_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = rsp_data;
          end else begin
            d_ack_d = 1'b1;
            if (!m_we_q) begin
              d_rdata_d = rsp_data;
            end
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      // The ack pulse is visible here; requests are deliberately not examined.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of statement order.
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_I;
      starve_q  <= '0;
      timer_q   <= '0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      timer_q   <= timer_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign i_rdata   = i_rdata_q;
  assign i_ack     = i_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign m_en      = m_en_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign err       = err_q;

  assign stall_if  = i_req & ~i_ack_q;
  assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle-numbered transaction model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall_if;
  logic          stall_mem;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          err;

  mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit chk_on  = 1'b0;

  // ---------------- memory environment ----------------
  bit mem_on      = 1'b1;
  int mem_lat     = 0;     // cycles from m_en to m_ack; 0 = same cycle
  bit m_ack_force = 1'b0;
  int since_en    = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h8C01_0004;
      32'h40:  return 32'h1234_5678;
      default: return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  // Writes return junk on the read bus so a wrongly captured store is visible.
  assign m_rdata = m_we ? 32'hDEAD_BEEF : mem_word(m_addr);
  assign m_ack   = m_ack_force |
                   (mem_on & ((mem_lat == 0) ? m_en : (since_en == mem_lat)));

  always @(posedge clk) begin
    if (rst)                since_en <= 0;
    else if (m_en && !m_ack) since_en <= 1;
    else if (m_ack)         since_en <= 0;
    else if (since_en > 0)  since_en <= since_en + 1;
  end

  // ---------------- reference model ----------------
  // Tracks the last grant by cycle numbers: when its strobe appears, when its ack
  // appears, and the earliest cycle a new grant may be made.
  bit          busy_m    = 1'b0;
  int          t_en      = -1;
  int          t_ack     = -1;
  int          free_at   = 0;
  int          n_starve  = 0;
  bit          own_d     = 1'b0;
  bit          e_we      = 1'b0;
  logic [31:0] e_addr    = '0;
  logic [31:0] e_wdata   = '0;
  logic [31:0] e_i_rdata = '0;
  logic [31:0] e_d_rdata = '0;
  bit          e_err     = 1'b0;
  string       model_order = "";

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      busy_m    <= 1'b0;
      t_en      <= -1;
      t_ack     <= -1;
      free_at   <= cyc + 1;
      n_starve  <= 0;
      own_d     <= 1'b0;
      e_we      <= 1'b0;
      e_addr    <= '0;
      e_wdata   <= '0;
      e_i_rdata <= '0;
      e_d_rdata <= '0;
      e_err     <= 1'b0;
    end else if (busy_m) begin
      if (m_ack || (cyc - t_en + 1 == TMO)) begin
        busy_m  <= 1'b0;
        t_ack   <= cyc + 1;
        free_at <= cyc + 2;
        if (!m_ack) e_err <= 1'b1;
        if (!own_d) e_i_rdata <= m_ack ? m_rdata : 32'h0;
        else if (!e_we) e_d_rdata <= m_ack ? m_rdata : 32'h0;
      end
    end else if (cyc >= free_at && (i_req || d_req)) begin
      busy_m <= 1'b1;
      t_en   <= cyc + 1;
      if (d_req && !(i_req && n_starve == SMAX)) begin
        own_d       <= 1'b1;
        e_we        <= d_we;
        e_addr      <= d_addr;
        e_wdata     <= d_wdata;
        n_starve    <= i_req ? ((n_starve < SMAX) ? n_starve + 1 : SMAX) : 0;
        model_order <= {model_order, "D"};
      end else begin
        own_d       <= 1'b0;
        e_we        <= 1'b0;
        e_addr      <= i_addr;
        e_wdata     <= 32'h0;
        n_starve    <= 0;
        model_order <= {model_order, "I"};
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_str(input string name, input string act, input string exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got '%s', want '%s'", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      bit ea_i;
      bit ea_d;
      ea_i = (cyc == t_ack) && !own_d;
      ea_d = (cyc == t_ack) && own_d;
      check("cmp_m_en",      m_en,      cyc == t_en);
      check("cmp_m_we",      m_we,      e_we);
      check("cmp_m_addr",    m_addr,    e_addr);
      check("cmp_m_wdata",   m_wdata,   e_wdata);
      check("cmp_i_ack",     i_ack,     ea_i);
      check("cmp_d_ack",     d_ack,     ea_d);
      check("cmp_i_rdata",   i_rdata,   e_i_rdata);
      check("cmp_d_rdata",   d_rdata,   e_d_rdata);
      check("cmp_err",       err,       e_err);
      check("cmp_stall_if",  stall_if,  i_req && !ea_i);
      check("cmp_stall_mem", stall_mem, d_req && !ea_d);
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int    acks;
    int    budget;
    int    ord_base;
    string dut_order;
    bit    got_i;
    bit    got_d;

    // reset state
    next();
    chk_on = 1'b1;
    mid();
    check("rst_m_en", m_en, 0);
    check("rst_err", err, 0);
    check("rst_i_ack", i_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_i_rdata", i_rdata, 0);
    next();
    rst = 1'b0;

    // 1: fetch only, memory acks with the strobe
    next();
    i_req = 1'b1; i_addr = 32'h10;
    mid();
    check("t1_stall_if_c0", stall_if, 1);
    check("t1_d_ack_c0", d_ack, 0);
    next(); mid();
    check("t1_m_en_c1", m_en, 1);
    check("t1_m_addr_c1", m_addr, 32'h10);
    check("t1_m_we_c1", m_we, 0);
    check("t1_stall_if_c1", stall_if, 1);
    next(); mid();
    check("t1_i_ack_c2", i_ack, 1);
    check("t1_i_rdata_c2", i_rdata, 32'h8C01_0004);
    check("t1_stall_if_c2", stall_if, 0);
    check("t1_d_ack_c2", d_ack, 0);
    next();
    i_req = 1'b0;

    // 2: simultaneous requests, data first
    next();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    i_req = 1'b1; i_addr = 32'h14;
    mid();
    check("t2_stall_mem_c0", stall_mem, 1);
    next(); mid();
    check("t2_m_en_c1", m_en, 1);
    check("t2_m_addr_c1", m_addr, 32'h40);
    next(); mid();
    check("t2_d_ack_c2", d_ack, 1);
    check("t2_d_rdata_c2", d_rdata, 32'h1234_5678);
    check("t2_i_ack_c2", i_ack, 0);
    next();
    d_req = 1'b0;
    mid();
    check("t2_m_en_c3", m_en, 0);
    check("t2_stall_if_c3", stall_if, 1);
    next(); mid();
    check("t2_m_en_c4", m_en, 1);
    check("t2_m_addr_c4", m_addr, 32'h14);
    next(); mid();
    check("t2_i_ack_c5", i_ack, 1);
    check("t2_i_rdata_c5", i_rdata, 32'h0014_FFEB);
    next();
    i_req = 1'b0;

    // 4: store leaves d_rdata untouched
    next();
    mem_lat = 2;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
    next(); mid();
    check("t4_m_en_c1", m_en, 1);
    check("t4_m_we_c1", m_we, 1);
    next(); mid();
    check("t4_m_en_c2", m_en, 0);
    check("t4_m_we_c2", m_we, 1);
    check("t4_m_wdata_c2", m_wdata, 32'hCAFE_F00D);
    next(); mid();
    check("t4_d_ack_c3", d_ack, 0);
    next(); mid();
    check("t4_d_ack_c4", d_ack, 1);
    check("t4_d_rdata_c4", d_rdata, 32'h1234_5678);
    next();
    d_req = 1'b0; d_we = 1'b0;
    mid();
    check("t4_d_ack_c5", d_ack, 0);
    check("t4_d_rdata_c5", d_rdata, 32'h1234_5678);

    // ack in the last permitted BUSY cycle beats the timeout
    next();
    mem_lat = 7;
    d_req = 1'b1; d_addr = 32'h44;
    for (int k = 1; k <= 8; k++) begin
      next(); mid();
      check("tl_d_ack_wait", d_ack, 0);
    end
    next(); mid();
    check("tl_d_ack_c9", d_ack, 1);
    check("tl_d_rdata_c9", d_rdata, 32'h0044_FFBB);
    check("tl_err_c9", err, 0);
    next();
    d_req = 1'b0;

    // 5: timeout with a dead memory
    next();
    mem_on = 1'b0; mem_lat = 0;
    i_req = 1'b1; i_addr = 32'h20;
    for (int k = 1; k <= 8; k++) begin
      next(); mid();
      check("t5_i_ack_wait", i_ack, 0);
      check("t5_err_wait", err, 0);
    end
    next(); mid();
    check("t5_i_ack_c9", i_ack, 1);
    check("t5_i_rdata_c9", i_rdata, 32'h0);
    check("t5_err_c9", err, 1);
    check("t5_model_err", e_err, 1);
    next();
    i_req = 1'b0;
    repeat (3) next();
    mid();
    check("t5_err_sticky", err, 1);

    // 3: starvation bound with both requesters always busy
    next();
    mem_on = 1'b1; mem_lat = 1;
    ord_base = model_order.len();
    dut_order = "";
    acks = 0; budget = 0;
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
    while (acks < 10 && budget < 300) begin
      mid();
      got_i = i_ack;
      got_d = d_ack;
      if (got_d) begin dut_order = {dut_order, "D"}; acks++; end
      if (got_i) begin dut_order = {dut_order, "I"}; acks++; end
      next();
      if (got_d) d_addr = d_addr + 32'h4;
      if (got_i) i_addr = i_addr + 32'h4;
      budget++;
    end
    i_req = 1'b0; d_req = 1'b0;
    check("t3_ack_count", acks, 10);
    check_str("t3_dut_order", dut_order, "DDDDIDDDDI");
    check_str("t3_model_order", model_order.substr(ord_base, ord_base + 9), "DDDDIDDDDI");
    check("t3_err_still_set", err, 1);

    // 6: reset in the middle of a transaction
    next();
    mem_on = 1'b0; mem_lat = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
    next(); mid();
    check("t6_m_en_c1", m_en, 1);
    next();
    next();
    rst = 1'b1; d_req = 1'b0;
    mid();
    check("t6_d_ack_c3", d_ack, 0);
    next();
    rst = 1'b0; m_ack_force = 1'b1;
    mid();
    check("t6_d_ack_c4", d_ack, 0);
    check("t6_err_c4", err, 0);
    check("t6_m_en_c4", m_en, 0);
    check("t6_m_addr_c4", m_addr, 32'h0);
    check("t6_d_rdata_c4", d_rdata, 32'h0);
    check("t6_i_rdata_c4", i_rdata, 32'h0);
    next();
    m_ack_force = 1'b0;
    mid();
    check("t6_d_ack_c5", d_ack, 0);
    check("t6_i_ack_c5", i_ack, 0);

    // normal service after reset
    next();
    mem_on = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    next();
    next(); mid();
    check("rec_i_ack", i_ack, 1);
    check("rec_i_rdata", i_rdata, 32'h8C01_0004);
    check("rec_err", err, 0);
    next();
    i_req = 1'b0;
    repeat (2) next();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
